// File: rtl/mem_responder_if.sv
// CPU request/response and external synchronous RAM signals for mem_responder.
// The responder takes the slave modport; whatever drives requests and models the RAM takes master.
interface mem_responder_if #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 10
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [WIDTH-1:0]         req_addr;
    logic [WIDTH-1:0]         req_wdata;
    logic                     rsp_valid;
    logic [WIDTH-1:0]         rsp_rdata;
    logic [RAM_ADDR_BITS-1:0] ram_addr;
    logic                     ram_we;
    logic [WIDTH-1:0]         ram_wdata;
    logic [WIDTH-1:0]         ram_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_responder.sv
// Load/store responder bridging a CPU request port to a synchronous RAM plus optional MMIO.
// Define MEM_RESPONDER_MMIO_EN to add the LED, cycle-counter and store-counter registers at 0xFF00-0xFFFF.
module mem_responder #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    mem_responder_if.slave   bus,
    output logic [WIDTH-1:0] led_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        RD_DONE,
        WR_DONE,
        IO_DONE
    } state_t;

    state_t state, next_state;
    logic   accept;
    logic   mmio_hit;

    assign accept = bus.req_valid && bus.req_ready;

`ifdef MEM_RESPONDER_MMIO_EN
    localparam logic [WIDTH-1:0] MMIO_BASE = WIDTH'(16'hFF00);

    logic [WIDTH-1:0] led_q;
    logic [WIDTH-1:0] cycle_cnt;
    logic [WIDTH-1:0] store_cnt;
    logic [WIDTH-1:0] mmio_rdata;
    logic             lat_write;

    assign mmio_hit = (bus.req_addr[WIDTH-1:8] == MMIO_BASE[WIDTH-1:8]);
    assign led_out  = led_q;

    always_comb begin
        mmio_rdata = '0;
        case (bus.req_addr[7:0])
            8'h00:   mmio_rdata = led_q;
            8'h01:   mmio_rdata = cycle_cnt;
            8'h02:   mmio_rdata = store_cnt;
            default: mmio_rdata = '0;
        endcase
    end

    // The LED is written at acceptance so it is visible in IO_DONE; the store
    // counter waits for the DONE state so an aborted store is never counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            cycle_cnt <= '0;
            store_cnt <= '0;
            lat_write <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + WIDTH'(1);
            if (accept)
                lat_write <= bus.req_write;
            if (accept && mmio_hit && bus.req_write && bus.req_addr[7:0] == 8'h00)
                led_q <= bus.req_wdata;
            if (state == WR_DONE || (state == IO_DONE && lat_write))
                store_cnt <= store_cnt + WIDTH'(1);
        end
    end
`else
    logic unused_addr_hi;

    assign mmio_hit       = 1'b0;
    assign led_out        = '0;
    assign unused_addr_hi = ^bus.req_addr[WIDTH-1:RAM_ADDR_BITS];
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.ram_we    = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (mmio_hit)
                        next_state = IO_DONE;
                    else if (bus.req_write)
                        next_state = WR_DONE;
                    else
                        next_state = RD_ISSUE;
                end
            end
            RD_ISSUE:   next_state = RD_CAPTURE;
            RD_CAPTURE: next_state = RD_DONE;
            RD_DONE: begin
                bus.rsp_valid = 1'b1;
                next_state    = IDLE;
            end
            WR_DONE: begin
                bus.rsp_valid = 1'b1;
                bus.ram_we    = 1'b1;
                next_state    = IDLE;
            end
            IO_DONE: begin
                bus.rsp_valid = 1'b1;
                next_state    = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ram_addr/ram_wdata double as the latched request; upper address bits alias.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            if (accept) begin
                bus.ram_addr  <= bus.req_addr[RAM_ADDR_BITS-1:0];
                bus.ram_wdata <= bus.req_wdata;
            end
            if (state == RD_CAPTURE)
                bus.rsp_rdata <= bus.ram_rdata;
`ifdef MEM_RESPONDER_MMIO_EN
            if (accept && mmio_hit && !bus.req_write)
                bus.rsp_rdata <= mmio_rdata;
`endif
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 10, external RAM word-address width.
REQ-003 SHALL have port clk, input, 1; the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1; CPU-side load/store request present.
REQ-006 SHALL have port req_ready, output, 1; request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_write, input, 1; 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, WIDTH; word address.
REQ-009 SHALL have port req_wdata, input, WIDTH; store data.
REQ-010 SHALL have port rsp_valid, output, 1; one-cycle pulse marking request completion.
REQ-011 SHALL have port rsp_rdata, output, WIDTH; load data, valid while rsp_valid=1.
REQ-012 SHALL have port ram_addr, output, RAM_ADDR_BITS; registered RAM address.
REQ-013 SHALL have port ram_we, output, 1; RAM write strobe.
REQ-014 SHALL have port ram_wdata, output, WIDTH; RAM write data.
REQ-015 SHALL have port ram_rdata, input, WIDTH; synchronous RAM read data, valid one cycle after ram_addr.
REQ-016 SHALL have port led_out, output, WIDTH; MMIO LED register contents.

Function
REQ-017 SHALL implement states IDLE, RD_ISSUE, RD_CAPTURE, RD_DONE, WR_DONE, IO_DONE.
REQ-018 SHALL drive req_ready=1 only in IDLE; SHALL latch req_write, req_addr and req_wdata on acceptance.
REQ-019 SHALL treat addresses 0xFF00-0xFFFF as MMIO (when enabled) and all others as RAM; ram_addr = latched req_addr[RAM_ADDR_BITS-1:0], upper bits ignored (aliasing).
REQ-020 RAM load accepted in cycle T: RD_ISSUE at T+1 (ram_addr valid), RD_CAPTURE at T+2 (rsp_rdata <= ram_rdata), RD_DONE at T+3 with rsp_valid=1.
REQ-021 RAM store accepted in cycle T: WR_DONE at T+1 with ram_we=1, ram_wdata = latched data, rsp_valid=1.
REQ-022 MMIO access accepted in cycle T: IO_DONE at T+1 with rsp_valid=1; register read/write takes effect at T+1.
REQ-023 MMIO map: 0xFF00 LED (read/write), 0xFF01 free-running cycle counter (read-only), 0xFF02 store counter (read-only), other 0xFFxx read 0x0000 with writes ignored.
REQ-024 A write to a read-only MMIO address SHALL be ignored but still complete with rsp_valid.
REQ-025 The cycle counter SHALL increment every clock, wrapping 0xFFFF -> 0x0000.
REQ-026 The store counter SHALL increment on every completed store (RAM or MMIO), wrapping 0xFFFF -> 0x0000.
REQ-027 All DONE states SHALL return to IDLE next cycle; minimum spacing between accepts = latency + 1.
REQ-028 ram_we SHALL be 0 in every state except WR_DONE; rsp_valid SHALL be 0 outside DONE states.
REQ-029 rsp_rdata SHALL hold its last value when rsp_valid=0; for stores its value is don't-care.

Reset
REQ-030 On reset: state IDLE, rsp_valid=0, rsp_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, led_out=0, both counters=0.
REQ-031 Reset asserted mid-transaction SHALL abort it: no ram_we, no rsp_valid, no counter or LED update.

Configuration
REQ-032 With macro MEM_RESPONDER_MMIO_EN defined, MMIO decode and the registers of REQ-023 to REQ-026 SHALL be present.
REQ-033 Without MEM_RESPONDER_MMIO_EN, all addresses SHALL go to RAM, IO_DONE SHALL be unreachable, and led_out SHALL be held at 0.

Verification
REQ-034 Store 0x1234 to 0x0005, then load 0x0005 -> ram_we=1 at T+1 with ram_addr=0x005, later rsp_rdata=0x1234 with rsp_valid exactly 3 cycles after load accept.
REQ-035 Store 0xBEEF to 0xFF00 -> led_out=0xBEEF next cycle, rsp_valid=1 at T+1, ram_we stays 0; load 0xFF00 returns 0xBEEF.
REQ-036 Store 0x0001 to 0xFF01 -> counter unaffected (continues incrementing), rsp_valid=1; three completed stores -> load 0xFF02 returns 0x0003.
REQ-037 req_valid held high continuously with loads -> req_ready low in RD_ISSUE/RD_CAPTURE/RD_DONE, one accept per 4 cycles.
REQ-038 Reset asserted in RD_CAPTURE -> rsp_valid never pulses, state IDLE, req_ready=1 on the cycle after reset deasserts.
REQ-039 Build without MEM_RESPONDER_MMIO_EN, store 0x00AA to 0xFF00 -> ram_we=1 with ram_addr=0x300 (RAM_ADDR_BITS=10), led_out=0.
